// File: rtl/axi_frame_reader_if.sv
// Bus bundle for the frame reader: AXI4 read address/data channels and the
// AXI4-Stream video output, with the reader as master and memory/display as slave.
interface axi_frame_reader_if;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_frame_reader.sv
// Frame scan-out: issues credit-limited AXI4 INCR bursts over a raster frame buffer
// and replays the pixels through a FIFO as an AXI4-Stream video stream (SOF/EOL).
module axi_frame_reader #(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  axi_frame_reader_if.master  bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o
);

  localparam int NB = FRAME_WIDTH * FRAME_HEIGHT / BURST_LEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [31:0] ADDR_STEP = 32'(BURST_LEN * 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_arvalid;
  logic            r_error;
  logic [31:0]     r_araddr;
  logic [BW-1:0]   r_ar_cnt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_inflight;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [23:0]     r_mem [FIFO_DEPTH];
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;

  logic            w_ar_hs;
  logic            w_push;
  logic            w_pop;
  logic            w_tvalid;
  logic            w_x_last;
  logic            w_y_last;
  logic            w_final;
  logic            w_last_burst;
  logic [CW-1:0]   w_credit;
  logic            w_unused;

  assign w_ar_hs      = r_arvalid & bus.m_axi_arready;
  assign w_push       = r_busy & bus.m_axi_rvalid;
  assign w_tvalid     = (r_count != '0);
  assign w_pop        = w_tvalid & bus.m_axis_tready;
  assign w_x_last     = (r_x == XW'(FRAME_WIDTH - 1));
  assign w_y_last     = (r_y == YW'(FRAME_HEIGHT - 1));
  assign w_final      = w_pop & w_x_last & w_y_last;
  assign w_last_burst = (r_ar_cnt == BW'(NB - 1));
  // Space not yet promised to the FIFO; in-flight beats are already reserved.
  assign w_credit     = CW'(FIFO_DEPTH) - r_count - r_inflight;
  assign w_unused     = &{1'b0, bus.m_axi_rlast, bus.m_axi_rdata[31:24]};

  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'h2;
  assign bus.m_axi_arburst = 2'h1;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_busy;
  assign bus.m_axis_tdata  = r_mem[r_rd_ptr];
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tuser  = w_tvalid & (r_x == '0) & (r_y == '0);
  assign bus.m_axis_tlast  = w_tvalid & w_x_last;

  assign busy_o  = r_busy;
  assign done_o  = w_final;
  assign error_o = r_error;

  // Control FSM: frame sequencing and AR issue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_ar_cnt  <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_error  <= 1'b0;
            r_araddr <= base_addr_i;
            r_ar_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_araddr  <= r_araddr + ADDR_STEP;
            r_ar_cnt  <= r_ar_cnt + BW'(1);
            if (w_last_burst) r_state <= S_DRAIN;
          end else if (!r_arvalid && (w_credit >= CW'(BURST_LEN))) begin
            r_arvalid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_final) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push && (bus.m_axi_rresp != 2'b00)) r_error <= 1'b1;
    end
  end

  // Credit accounting: AR reserves a full burst, each R beat releases one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_ar_hs, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(BURST_LEN);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        2'b11:   r_inflight <= r_inflight + CW'(BURST_LEN) - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Pixel FIFO control
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.m_axi_rdata[23:0];
  end

  // Output raster position
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_frame_reader.sv
// Directed bench for axi_frame_reader on an 8x4 frame, 4-beat bursts, 8-entry FIFO,
// with a behavioural AXI memory and a stream monitor.
module tb_axi_frame_reader;
  localparam int W = 8, H = 4, BL = 4, DEPTH = 8;
  localparam int NPIX = W * H;
  localparam int NBUR = NPIX / BL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = 32'h0;
  logic        busy, done, error;

  axi_frame_reader_if bus();

  axi_frame_reader #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
    .bus(bus), .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ar_q[$];
  logic [31:0] ar_log[$];
  logic [23:0] px_q[$];
  bit          usr_q[$];
  bit          lst_q[$];
  int beat = 0, g_beat = 0, err_beat = -1, ar_block = 0;
  int stall_cnt = 0, stab_viol = 0, done_cnt = 0, pops = 0, max_hold = 0, max_out = 0;
  bit ar_pend = 0, r_pend = 0, prev_arv = 0, done_prev = 0;
  logic [31:0] pend_addr, prev_araddr, a;
  logic err_before, err_after, err_at_done, busy_after_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ar_log.delete(); px_q.delete(); usr_q.delete(); lst_q.delete();
    pops = 0; max_hold = 0; max_out = 0; done_cnt = 0; g_beat = 0;
  endtask

  task automatic start_frame(input logic [31:0] b);
    base = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_ars(input int n, input string tag);
    for (int i = 0; i < 500 && ar_log.size() < n; i++) tick(1);
    chk(tag, ar_log.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick(1);
    tick(3);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_after_done"}, busy_after_done, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_fifo_empty"}, bus.m_axis_tvalid, 1'b0);
  endtask

  task automatic check_frame(input logic [31:0] b, input string tag);
    logic [31:0] exp_base;
    exp_base = b >> 2;
    chk({tag, "_ar_count"}, ar_log.size(), NBUR);
    for (int i = 0; i < NBUR; i++)
      chk($sformatf("%s_araddr%0d", tag, i), ar_log[i], b + 32'(i * BL * 4));
    chk({tag, "_px_count"}, px_q.size(), NPIX);
    for (int k = 0; k < NPIX; k++) begin
      chk($sformatf("%s_px%0d", tag, k), px_q[k], exp_base[23:0] + 24'(k));
      chk($sformatf("%s_tuser%0d", tag, k), usr_q[k], k == 0);
      chk($sformatf("%s_tlast%0d", tag, k), lst_q[k], (k % W) == (W - 1));
    end
  endtask

  // AXI memory responder and stream monitor, acting on the falling edge
  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_q.delete(); beat = 0; ar_pend = 0; r_pend = 0; prev_arv = 0; done_prev = 0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
      end else begin
        if (prev_arv && !ar_pend &&
            (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== prev_araddr))
          stab_viol++;
        if (ar_pend) begin
          ar_q.push_back(pend_addr);
          ar_log.push_back(pend_addr);
        end
        if (r_pend) begin
          if (g_beat == err_beat) err_after = error;
          g_beat++;
          beat++;
          if (beat == BL) begin
            beat = 0;
            void'(ar_q.pop_front());
          end
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          px_q.push_back(bus.m_axis_tdata);
          usr_q.push_back(bus.m_axis_tuser);
          lst_q.push_back(bus.m_axis_tlast);
          pops++;
        end
        if (done_prev) busy_after_done = busy;
        if (done) begin
          done_cnt++;
          err_at_done = error;
        end
        done_prev = done;

        bus.m_axi_arready = (ar_block == 0);
        if (ar_block > 0) ar_block--;
        if (bus.m_axi_arvalid && !bus.m_axi_arready) stall_cnt++;
        bus.m_axi_rvalid = (ar_q.size() > 0);
        if (ar_q.size() > 0) begin
          a = ar_q[0] + 32'(beat * 4);
          bus.m_axi_rdata = {8'hEE, a[25:2]};
          bus.m_axi_rlast = (beat == BL - 1);
          bus.m_axi_rresp = (g_beat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_rlast = 1'b0;
          bus.m_axi_rresp = 2'b00;
        end

        ar_pend   = bus.m_axi_arvalid && bus.m_axi_arready;
        pend_addr = bus.m_axi_araddr;
        r_pend    = bus.m_axi_rvalid && bus.m_axi_rready;
        if (r_pend && g_beat == err_beat) err_before = error;
        prev_arv    = bus.m_axi_arvalid;
        prev_araddr = bus.m_axi_araddr;
        if (ar_log.size() * BL - pops > max_hold) max_hold = ar_log.size() * BL - pops;
        if (ar_q.size() > max_out) max_out = ar_q.size();
      end
    end
  end

  initial begin
    bus.m_axis_tready = 1'b0;
    tick(3);
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_araddr", bus.m_axi_araddr, 32'h0);
    chk("rst_rready", bus.m_axi_rready, 1'b0);
    chk("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_tuser", bus.m_axis_tuser, 1'b0);
    chk("rst_tlast", bus.m_axis_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("arlen", bus.m_axi_arlen, 8'd3);
    chk("arsize", bus.m_axi_arsize, 3'h2);
    chk("arburst", bus.m_axi_arburst, 2'h1);
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    tick(2);

    // Plain frame with a free-running sink
    clear_logs();
    start_frame(32'h1000_0000);
    chk("t1_busy_rise", busy, 1'b1);
    chk("t1_error_clr", error, 1'b0);
    chk("t1_arvalid_late", bus.m_axi_arvalid, 1'b0);
    chk("t1_rready", bus.m_axi_rready, 1'b1);
    wait_done("t1");
    check_frame(32'h1000_0000, "t1");

    // Back-pressured sink: credits cap outstanding reads at two bursts
    clear_logs();
    bus.m_axis_tready = 1'b0;
    start_frame(32'h1000_0000);
    tick(40);
    chk("t2_ars_capped", ar_log.size(), 2);
    chk("t2_arvalid_low", bus.m_axi_arvalid, 1'b0);
    chk("t2_no_pops", pops, 0);
    chk("t2_tvalid", bus.m_axis_tvalid, 1'b1);
    chk("t2_tuser_held", bus.m_axis_tuser, 1'b1);
    chk("t2_tdata_held", bus.m_axis_tdata, 24'h0);
    chk("t2_maxout_le2", max_out <= 2, 1'b1);
    bus.m_axis_tready = 1'b1;
    wait_done("t2");
    chk("t2_hold", max_hold, DEPTH);
    check_frame(32'h1000_0000, "t2");

    // Error response on beat 5
    clear_logs();
    err_beat = 5;
    start_frame(32'h1000_0000);
    wait_done("t3");
    chk("t3_err_before", err_before, 1'b0);
    chk("t3_err_after", err_after, 1'b1);
    chk("t3_err_at_done", err_at_done, 1'b1);
    chk("t3_err_sticky", error, 1'b1);
    check_frame(32'h1000_0000, "t3");
    err_beat = -1;

    // Restart attempt mid-frame is ignored
    clear_logs();
    start_frame(32'h1000_0000);
    chk("t4_err_cleared", error, 1'b0);
    wait_ars(3, "t4_wait_ars");
    start_frame(32'h3000_0000);
    chk("t4_still_busy", busy, 1'b1);
    wait_done("t4");
    check_frame(32'h1000_0000, "t4");

    // Reset mid-frame, then a fresh frame at a new base
    clear_logs();
    start_frame(32'h1000_0000);
    wait_ars(3, "t5_wait_ars");
    rst = 1'b1;
    #1;
    chk("t5_rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("t5_rst_araddr", bus.m_axi_araddr, 32'h0);
    chk("t5_rst_rready", bus.m_axi_rready, 1'b0);
    chk("t5_rst_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("t5_rst_tuser", bus.m_axis_tuser, 1'b0);
    chk("t5_rst_tlast", bus.m_axis_tlast, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_error", error, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
    clear_logs();
    start_frame(32'h2000_0100);
    wait_done("t5");
    check_frame(32'h2000_0100, "t5");

    // Address channel stalled for 10 cycles on the first burst
    clear_logs();
    start_frame(32'h1000_0000);
    for (int i = 0; i < 100 && bus.m_axi_arvalid !== 1'b1; i++) tick(1);
    chk("t6_arvalid_seen", bus.m_axi_arvalid, 1'b1);
    ar_block = 10;
    stall_cnt = 0;
    wait_done("t6");
    chk("t6_stall_cycles", stall_cnt, 10);
    check_frame(32'h1000_0000, "t6");

    chk("ar_stability", stab_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
